// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO, on the data bus.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r,
    input  logic [3:0]  w,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overrun;
    logic [15:0]        r_div;

    state_t             r_state;
    logic [7:0]         r_shreg;
    logic [15:0]        r_div_q;
    logic [15:0]        r_divcnt;
    logic [2:0]         r_bitcnt;
    logic               r_tx;

    logic        w_sel;
    logic        w_wr;
    logic [1:0]  w_off;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic [15:0] w_eff_div;
    logic        w_bit_done;
    logic        w_unused;

    assign w_sel      = (addr[31:4] == BASE[31:4]);
    assign w_off      = addr[3:2];
    assign w_wr       = w_sel && (w != 4'b0000);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_CNT);
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_push_req = w_wr && (w_off == 2'd0) && w[0];
    // A full FIFO still accepts a byte when the serializer frees a slot this cycle
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_busy     = !w_empty || (r_state != S_IDLE);
    assign w_eff_div  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_bit_done = (r_divcnt == (r_div_q - 16'd1));
    assign w_unused   = &{1'b0, in[31:16], addr[1:0]};

    assign sel  = w_sel;
    assign tx   = r_tx;
    assign busy = w_busy;

    always_comb begin
        out = 32'd0;
        if (w_sel && r) begin
            case (w_off)
                2'd1:    out = {28'd0, r_overrun, w_empty, w_full, w_busy};
                2'd2:    out = {16'd0, r_div};
                default: out = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_div     <= DEFAULT_DIV;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end else if (w_wr && (w_off == 2'd1) && w[0] && in[3]) begin
                r_overrun <= 1'b0;
            end
            if (w_wr && (w_off == 2'd2)) begin
                if (w[0]) r_div[7:0]  <= in[7:0];
                if (w[1]) r_div[15:8] <= in[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_shreg  <= 8'd0;
            r_div_q  <= 16'd1;
            r_divcnt <= 16'd0;
            r_bitcnt <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shreg  <= r_mem[r_rd_ptr];
                        r_div_q  <= w_eff_div;
                        r_divcnt <= 16'd0;
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_divcnt <= 16'd0;
                        r_bitcnt <= 3'd0;
                        r_state  <= S_DATA;
                        r_tx     <= r_shreg[0];
                    end else begin
                        r_divcnt <= r_divcnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_divcnt <= 16'd0;
                        r_shreg  <= r_shreg >> 1;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            // tx is registered, so present the bit the shift brings down
                            r_tx <= r_shreg[1];
                        end
                    end else begin
                        r_divcnt <= r_divcnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_divcnt <= 16'd0;
                        r_state  <= S_IDLE;
                        r_tx     <= 1'b1;
                    end else begin
                        r_divcnt <= r_divcnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
